// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between the core and a debug/loader port
module dmem_arbiter #(
    parameter int MAX_CPU_WINS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [3:0] MAX_WINS = 4'(MAX_CPU_WINS);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       cpu_acc;
    logic       dbg_serve;

    assign cpu_acc   = cpu_mem_read | cpu_mem_write;
    // Debug owns the port when the core is idle or has used up its consecutive wins.
    assign dbg_serve = !reset && (state == IDLE) && dbg_req &&
                       (!cpu_acc || (wait_cnt >= MAX_WINS));
    // Only a contended debug win freezes the core; an uncontended one is invisible to it.
    assign cpu_stall = dbg_serve && cpu_acc;
    assign cpu_rdata = mem_rdata;

    // Memory port mux; both enables are forced low during reset.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else if (dbg_serve) begin
            mem_read  = !dbg_we;
            mem_write = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_read  = cpu_mem_read;
            mem_write = cpu_mem_write;
        end
    end

    // Two-state service FSM with starvation counter and registered ack/read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= 32'd0;
        end else begin
            dbg_ack <= dbg_serve;
            case (state)
                IDLE: begin
                    if (dbg_serve) begin
                        state    <= ACK;
                        wait_cnt <= 4'd0;
                        if (!dbg_we) begin
                            dbg_rdata <= mem_rdata;
                        end
                    end else if (dbg_req && cpu_acc) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end else begin
                        wait_cnt <= 4'd0;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int checks;
    int errors;

    dmem_arbiter #(.MAX_CPU_WINS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_mem_read (cpu_mem_read),
        .cpu_mem_write(cpu_mem_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .dbg_rdata    (dbg_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem model: combinational read, synchronous write
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_mem_read  = r;
        cpu_mem_write = w;
        cpu_addr      = a;
        cpu_wdata     = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        dbg_req   = req;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_cpu(1'b1, 1'b1, 32'h40, 32'h1);
        set_dbg(1'b1, 1'b1, 32'h44, 32'h2);
        @(negedge clk);
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %0h exp 0", mem_write); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got %0h exp 0", mem_read); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall got %0h exp 0", cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL rst_dbg_ack got %0h exp 0", dbg_ack); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_dbg_rdata got %h exp 00000000", dbg_rdata); end
        next_cycle();
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_cpu_only;
        set_cpu(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cpu_store got w=%0h a=%h d=%h exp w=1 a=00000010 d=deadbeef", mem_write, mem_addr, mem_wdata); end
        checks++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
            errors++; $display("FAIL cpu_store_side got stall=%0h ack=%0h exp 0 0", cpu_stall, dbg_ack); end
        next_cycle();
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_load got %h exp deadbeef", cpu_rdata); end
        checks++; if (mem_read !== 1'b1 || cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
            errors++; $display("FAIL cpu_load_side got rd=%0h stall=%0h ack=%0h exp 1 0 0", mem_read, cpu_stall, dbg_ack); end
        next_cycle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_dbg_write_read;
        set_dbg(1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
            errors++; $display("FAIL dw_serve got w=%0h a=%h d=%h exp w=1 a=00000020 d=12345678", mem_write, mem_addr, mem_wdata); end
        checks++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL dw_serve_side got ack=%0h stall=%0h exp 0 0", dbg_ack, cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dw_ack got %0h exp 1", dbg_ack); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL dw_ack_no_write got %0h exp 0", mem_write); end
        next_cycle();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dw_ack_single got %0h exp 0", dbg_ack); end
        next_cycle();
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL dr_serve got rd=%0h a=%h exp 1 00000020", mem_read, mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h12345678) begin
            errors++; $display("FAIL dr_ack got ack=%0h data=%h exp 1 12345678", dbg_ack, dbg_rdata); end
        next_cycle();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_contention;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (cpu_stall !== 1'b0 || mem_addr !== 32'h10 || dbg_ack !== 1'b0) begin
                errors++; $display("FAIL cont_cpu_win%0d got stall=%0h a=%h ack=%0h exp 0 00000010 0", i, cpu_stall, mem_addr, dbg_ack); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h20 || mem_read !== 1'b1) begin
            errors++; $display("FAIL cont_dbg_win got stall=%0h a=%h rd=%0h exp 1 00000020 1", cpu_stall, mem_addr, mem_read); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h12345678 || cpu_stall !== 1'b0 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL cont_ack got ack=%0h data=%h stall=%0h a=%h exp 1 12345678 0 00000010", dbg_ack, dbg_rdata, cpu_stall, mem_addr); end
        next_cycle();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
    endtask

    task automatic test_collide;
        set_cpu(1'b0, 1'b1, 32'h30, 32'hC0C0C0C0);
        set_dbg(1'b1, 1'b1, 32'h30, 32'hD0D0D0D0);
        for (int i = 0; i < 4; i++) next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== 32'hD0D0D0D0) begin
            errors++; $display("FAIL col_dbg_win got stall=%0h w=%0h d=%h exp 1 1 d0d0d0d0", cpu_stall, mem_write, mem_wdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hD0D0D0D0) begin errors++; $display("FAIL col_dbg_landed got %h exp d0d0d0d0", cpu_rdata); end
        checks++; if (dbg_ack !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== 32'hC0C0C0C0) begin
            errors++; $display("FAIL col_cpu_retry got ack=%0h w=%0h d=%h exp 1 1 c0c0c0c0", dbg_ack, mem_write, mem_wdata); end
        next_cycle();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        set_cpu(1'b1, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hC0C0C0C0) begin errors++; $display("FAIL col_final got %h exp c0c0c0c0", cpu_rdata); end
        next_cycle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_rd;
        logic [3:0] exp_ack;
        exp_rd  = 4'b0101;
        exp_ack = 4'b1010;
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mem_read !== exp_rd[i] || dbg_ack !== exp_ack[i]) begin
                errors++; $display("FAIL b2b_cyc%0d got rd=%0h ack=%0h exp %0h %0h", i, mem_read, dbg_ack, exp_rd[i], exp_ack[i]); end
            next_cycle();
        end
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL b2b_end got ack=%0h exp 0", dbg_ack); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        set_dbg(1'b1, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 3; i++) next_cycle();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("FAIL rmid_in_reset got rd=%0h stall=%0h exp 0 0", mem_read, cpu_stall); end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || mem_addr !== 32'h10) begin
                errors++; $display("FAIL rmid_wait%0d got stall=%0h ack=%0h a=%h exp 0 0 00000010", i, cpu_stall, dbg_ack, mem_addr); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL rmid_dbg_win got stall=%0h a=%h exp 1 00000020", cpu_stall, mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL rmid_ack got %0h exp 1", dbg_ack); end
        next_cycle();
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        test_reset();
        test_cpu_only();
        test_dbg_write_read();
        test_contention();
        test_collide();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-clock arbiter that shares the single-ported data memory between the single-cycle RV32I core and a debug/loader port. It sits between the core's load/store signals and `data_mem`, so debug reads and writes can run while the program is running. The core has default priority. A starvation counter bounds the debug wait, and when debug must win a contended cycle the block asserts a same-cycle stall that freezes the core for that cycle.

## Interface
- `MAX_CPU_WINS`, default 4: maximum consecutive contended cycles the core may win while debug waits. Legal range 1..15.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_mem_read`  in  1  core load this cycle.
- `cpu_mem_write`  in  1  core store this cycle.
- `cpu_addr`  in  32  core address, i.e. the ALU result.
- `cpu_wdata`  in  32  core store data, i.e. rs2.
- `cpu_rdata`  out  32  load data to the core; always equals `mem_rdata`.
- `cpu_stall`  out  1  combinational. When 1, the core must hold its PC and suppress RegWrite.
- `dbg_req`  in  1  debug access request. Held, with `dbg_we`/`dbg_addr`/`dbg_wdata` stable, until `dbg_ack`.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  32  debug address.
- `dbg_wdata`  in  32  debug write data.
- `dbg_ack`  out  1  registered one-cycle completion pulse.
- `dbg_rdata`  out  32  registered read data. Valid while `dbg_ack` = 1; holds until the next debug service.
- `mem_read`  out  1  to `data_mem.MemRead`.
- `mem_write`  out  1  to `data_mem.MemWrite`.
- `mem_addr`  out  32  to `data_mem.addr`.
- `mem_wdata`  out  32  to `data_mem.write_data`.
- `mem_rdata`  in  32  from `data_mem.read_data`. Combinational read; write is synchronous.

## Operation
- Definitions:
  - `cpu_acc` = `cpu_mem_read | cpu_mem_write`.
  - `wait_cnt` is a 4-bit counter.
  - Two-state FSM: IDLE and ACK.
- IDLE, `dbg_req` = 0: the core owns memory. `mem_*` follow `cpu_*`, `cpu_stall` = 0, `wait_cnt` ← 0.
- IDLE, `dbg_req` = 1, `cpu_acc` = 0: the debug access is served this cycle.
  - `mem_read` = !`dbg_we`, `mem_write` = `dbg_we`; `mem_addr`/`mem_wdata` come from the `dbg_*` inputs.
  - `cpu_stall` = 0.
  - At the edge: `dbg_rdata` ← `mem_rdata` (reads only; unchanged on writes), `wait_cnt` ← 0, go to ACK.
- IDLE, `dbg_req` = 1, `cpu_acc` = 1, `wait_cnt` < `MAX_CPU_WINS`: the core is served and `cpu_stall` = 0. `wait_cnt` ← `wait_cnt` + 1.
- IDLE, `dbg_req` = 1, `cpu_acc` = 1, `wait_cnt` = `MAX_CPU_WINS`: debug is served as in the uncontended case and `cpu_stall` = 1. The core's store is not forwarded and it re-executes the same instruction next cycle.
- ACK: `dbg_ack` = 1 for exactly this cycle.
  - `dbg_req` is ignored in this cycle and the core owns memory, as in IDLE with `dbg_req` = 0.
  - Go to IDLE. A still-asserted `dbg_req` in the next cycle counts as a new request.
- If `dbg_req` drops in IDLE before service (protocol violation), no debug access occurs and `wait_cnt` ← 0.
- `cpu_stall` is asserted only in a debug-wins contended cycle.
- `mem_write` is never 1 for both requesters in the same cycle.

## Timing
- Reset (cycle with `reset` = 1):
  - Registers: FSM ← IDLE, `wait_cnt` ← 0, `dbg_ack` ← 0, `dbg_rdata` ← 0.
  - Combinational outputs during reset: `mem_read` = 0, `mem_write` = 0, `cpu_stall` = 0.
- Reset mid-operation: a waiting or just-served request gets no ack. A request still held after reset deasserts is treated as new, starting with `wait_cnt` = 0.
- Debug latency, request first seen in cycle N:
  - Core idle: served in N, `dbg_ack` in N+1.
  - Core accessing memory every cycle: served in N+`MAX_CPU_WINS`, ack in N+`MAX_CPU_WINS`+1.
- Maximum debug throughput: one access per 2 cycles.
- Core throughput under a continuous debug stream: at most 1 stall per `MAX_CPU_WINS`+2 cycles.
- A debug write takes effect at the edge ending its service cycle. A core load in the ACK cycle sees the new value.

## Test plan
- No debug traffic; core stores 0xDEADBEEF to 0x10, then loads 0x10 → `cpu_rdata` = 0xDEADBEEF, `cpu_stall` never 1, `dbg_ack` never 1.
- Core idle; debug write 0x12345678 to 0x20 issued at cycle 5 → `mem_write` = 1 in cycle 5, `dbg_ack` = 1 in cycle 6 only. Debug read of 0x20 then returns `dbg_rdata` = 0x12345678.
- `MAX_CPU_WINS` = 4; core issues a load every cycle; debug read raised at cycle 10 → core served cycles 10–13, debug served with `cpu_stall` = 1 in cycle 14, `dbg_ack` in 15.
- Debug write and core store to the same address in a debug-wins cycle → only the debug data lands; the core store lands the next cycle, with the core data as the final value.
- `dbg_req` held continuously across ACK → second access served no earlier than 2 cycles after the first, each with a single one-cycle ack.
- `reset` pulsed while a debug request is waiting with `wait_cnt` = 3 → no ack; after reset the request restarts with the full wait of `MAX_CPU_WINS` contended cycles.
